// File: rtl/udp_datagram_receiver.sv
// udp_datagram_receiver: parses the 8-byte UDP header from the IP payload
// stream, filters on destination port, trims Ethernet padding using the UDP
// length field and forwards the payload to the application over AXI-Stream.
module udp_datagram_receiver #(
  parameter int DATA_WIDTH            = 8,
  parameter int UDP_HEADER_BYTE_COUNT = 8,
  parameter int PROMISCUOUS_ENABLE    = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  udp_rx_tready,
  input  logic                  udp_rx_tvalid,
  input  logic [DATA_WIDTH-1:0] udp_rx_tdata,
  input  logic                  udp_rx_tlast,
  input  logic                  app_rx_tready,
  output logic                  app_rx_tvalid,
  output logic [DATA_WIDTH-1:0] app_rx_tdata,
  output logic                  app_rx_tlast,
  input  logic [15:0]           local_udp_port,
  output logic [15:0]           source_udp_port,
  output logic [15:0]           dest_udp_port,
  output logic [15:0]           udp_length,
  output logic                  header_valid,
  output logic                  length_error,
  output logic [15:0]           drop_count
);

  typedef enum logic [1:0] {
    RECEIVE_HEADER,
    FORWARD_PAYLOAD,
    DROP_PAYLOAD
  } state_t;

  localparam logic [15:0] HDR_LEN  = 16'(UDP_HEADER_BYTE_COUNT);
  localparam logic [15:0] HDR_LAST = 16'(UDP_HEADER_BYTE_COUNT - 1);

  state_t      state;
  logic [15:0] hdr_count;
  logic [15:0] payload_remaining;
  logic [15:0] hdr_src, hdr_dst, hdr_len;

  logic rx_xfer;
  logic port_match;
  logic hdr_done;
  logic hdr_bad;
  logic drop_event;

  // Ready toward the IP layer; held low during reset so nothing is consumed.
  always_comb begin
    udp_rx_tready = 1'b0;
    if (!reset) begin
      case (state)
        RECEIVE_HEADER:  udp_rx_tready = 1'b1;
        DROP_PAYLOAD:    udp_rx_tready = 1'b1;
        FORWARD_PAYLOAD: udp_rx_tready = !app_rx_tvalid || app_rx_tready;
        default:         udp_rx_tready = 1'b0;
      endcase
    end
  end

  // Header completion/filter decode; a header ended early by tlast is always bad.
  always_comb begin
    rx_xfer    = udp_rx_tvalid && udp_rx_tready;
    port_match = (hdr_dst == local_udp_port) ||
                 ((PROMISCUOUS_ENABLE != 0) && (local_udp_port == 16'h0000));
    hdr_done   = (state == RECEIVE_HEADER) && rx_xfer &&
                 (udp_rx_tlast || (hdr_count == HDR_LAST));
    hdr_bad    = (hdr_count != HDR_LAST) || (hdr_len < HDR_LEN) || !port_match;
    drop_event = hdr_done && hdr_bad;
  end

  // Saturating count of dropped datagrams.
  always_ff @(posedge clock) begin
    if (reset)
      drop_count <= 16'h0000;
    else if (drop_event && (drop_count != 16'hFFFF))
      drop_count <= drop_count + 16'h0001;
  end

  // Main FSM: header capture, payload forwarding through a one-entry register, padding drop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= RECEIVE_HEADER;
      hdr_count         <= 16'h0000;
      payload_remaining <= 16'h0000;
      hdr_src           <= 16'h0000;
      hdr_dst           <= 16'h0000;
      hdr_len           <= 16'h0000;
      source_udp_port   <= 16'h0000;
      dest_udp_port     <= 16'h0000;
      udp_length        <= 16'h0000;
      header_valid      <= 1'b0;
      length_error      <= 1'b0;
      app_rx_tvalid     <= 1'b0;
      app_rx_tdata      <= '0;
      app_rx_tlast      <= 1'b0;
    end else begin
      header_valid <= 1'b0;
      length_error <= 1'b0;
      // Output register drains independently of state; a new load below wins.
      if (app_rx_tvalid && app_rx_tready) begin
        app_rx_tvalid <= 1'b0;
        app_rx_tlast  <= 1'b0;
      end
      case (state)
        RECEIVE_HEADER: begin
          if (rx_xfer) begin
            case (hdr_count)
              16'd0:   hdr_src[15:8] <= udp_rx_tdata[7:0];
              16'd1:   hdr_src[7:0]  <= udp_rx_tdata[7:0];
              16'd2:   hdr_dst[15:8] <= udp_rx_tdata[7:0];
              16'd3:   hdr_dst[7:0]  <= udp_rx_tdata[7:0];
              16'd4:   hdr_len[15:8] <= udp_rx_tdata[7:0];
              16'd5:   hdr_len[7:0]  <= udp_rx_tdata[7:0];
              default: ;
            endcase
            if (hdr_done) begin
              hdr_count <= 16'h0000;
              if (!hdr_bad) begin
                source_udp_port <= hdr_src;
                dest_udp_port   <= hdr_dst;
                udp_length      <= hdr_len;
                header_valid    <= 1'b1;
              end
              if (udp_rx_tlast) begin
                // Header ended with the frame: no payload can follow.
                if (!hdr_bad && (hdr_len != HDR_LEN))
                  length_error <= 1'b1;
              end else if (hdr_bad || (hdr_len == HDR_LEN)) begin
                state <= DROP_PAYLOAD;
              end else begin
                payload_remaining <= hdr_len - HDR_LEN;
                state             <= FORWARD_PAYLOAD;
              end
            end else begin
              hdr_count <= hdr_count + 16'h0001;
            end
          end
        end
        FORWARD_PAYLOAD: begin
          if (rx_xfer) begin
            app_rx_tvalid     <= 1'b1;
            app_rx_tdata      <= udp_rx_tdata;
            app_rx_tlast      <= udp_rx_tlast || (payload_remaining == 16'h0001);
            payload_remaining <= payload_remaining - 16'h0001;
            if (payload_remaining == 16'h0001) begin
              // Anything after the UDP length is Ethernet padding.
              state <= udp_rx_tlast ? RECEIVE_HEADER : DROP_PAYLOAD;
            end else if (udp_rx_tlast) begin
              length_error <= 1'b1;
              state        <= RECEIVE_HEADER;
            end
          end
        end
        DROP_PAYLOAD: begin
          if (rx_xfer && udp_rx_tlast)
            state <= RECEIVE_HEADER;
        end
        default: state <= RECEIVE_HEADER;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_datagram_receiver.sv
// Directed bench for udp_datagram_receiver with a datagram-level reference model.
module tb_udp_datagram_receiver;

  typedef byte unsigned bq_t[$];

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        udp_rx_tready;
  logic        udp_rx_tvalid = 1'b0;
  logic [7:0]  udp_rx_tdata = 8'h00;
  logic        udp_rx_tlast = 1'b0;
  logic        app_rx_tready = 1'b1;
  logic        app_rx_tvalid;
  logic [7:0]  app_rx_tdata;
  logic        app_rx_tlast;
  logic [15:0] lp = 16'h0400;
  logic [15:0] source_udp_port, dest_udp_port, udp_length, drop_count;
  logic        header_valid, length_error;

  udp_datagram_receiver dut (
    .clock(clock), .reset(reset),
    .udp_rx_tready(udp_rx_tready), .udp_rx_tvalid(udp_rx_tvalid),
    .udp_rx_tdata(udp_rx_tdata), .udp_rx_tlast(udp_rx_tlast),
    .app_rx_tready(app_rx_tready), .app_rx_tvalid(app_rx_tvalid),
    .app_rx_tdata(app_rx_tdata), .app_rx_tlast(app_rx_tlast),
    .local_udp_port(lp), .source_udp_port(source_udp_port),
    .dest_udp_port(dest_udp_port), .udp_length(udp_length),
    .header_valid(header_valid), .length_error(length_error),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int vectors = 0, miscompares = 0;
  bit toggle = 1'b0;

  // reference model expectations
  byte unsigned exp_data[$];
  bit           exp_last[$];
  int m_drop = 0, m_hv = 0, m_le = 0;

  // monitor observations
  int hv_seen = 0, le_seen = 0, rcv_count = 0;
  logic       prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0, prev_rst = 1'b1;
  logic [7:0] prev_d = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // App ready: constant 1, or alternating every cycle while toggle is set.
  always @(posedge clock) begin
    #1;
    app_rx_tready = toggle ? ~app_rx_tready : 1'b1;
  end

  // Compare process: every app transfer against the model, stall stability, pulse counts.
  always @(negedge clock) begin
    if (!reset && !prev_rst && prev_v && !prev_r) begin
      chk("hold_valid", {31'd0, app_rx_tvalid}, 32'd1);
      chk("hold_data", {24'd0, app_rx_tdata}, {24'd0, prev_d});
      chk("hold_last", {31'd0, app_rx_tlast}, {31'd0, prev_l});
    end
    if (app_rx_tvalid && app_rx_tready) begin
      rcv_count++;
      if (exp_data.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_byte: got %0h expected none", app_rx_tdata);
      end else begin
        chk("app_data", {24'd0, app_rx_tdata}, {24'd0, exp_data.pop_front()});
        chk("app_last", {31'd0, app_rx_tlast}, {31'd0, exp_last.pop_front()});
      end
    end
    if (header_valid) hv_seen++;
    if (length_error) le_seen++;
    prev_v = app_rx_tvalid; prev_r = app_rx_tready;
    prev_d = app_rx_tdata;  prev_l = app_rx_tlast; prev_rst = reset;
  end

  function automatic bq_t mk(input logic [15:0] s, input logic [15:0] d,
                             input logic [15:0] l, input int np, input byte unsigned base);
    bq_t q;
    q.push_back(s[15:8]); q.push_back(s[7:0]);
    q.push_back(d[15:8]); q.push_back(d[7:0]);
    q.push_back(l[15:8]); q.push_back(l[7:0]);
    q.push_back(8'hAB);   q.push_back(8'hCD);
    for (int i = 0; i < np; i++) q.push_back(8'(base + i));
    return q;
  endfunction

  // Datagram-level model: what the application must see for one whole frame.
  function automatic void model(input bq_t d, input logic [15:0] port);
    int n, need, avail, fwd;
    logic [15:0] dst, len;
    n = d.size();
    if (n < 8) begin m_drop++; return; end
    dst = {d[2], d[3]};
    len = {d[4], d[5]};
    if (len < 16'd8 || dst != port) begin m_drop++; return; end
    m_hv++;
    need  = int'(len) - 8;
    avail = n - 8;
    fwd   = (need < avail) ? need : avail;
    for (int i = 0; i < fwd; i++) begin
      exp_data.push_back(d[8 + i]);
      exp_last.push_back(i == fwd - 1);
    end
    if (need > avail) m_le++;
  endfunction

  // Drives bytes; called at posedge+1, returns at posedge+1 after the last transfer.
  task automatic send(input bq_t d, input bit tlast_at_end);
    for (int i = 0; i < d.size(); i++) begin
      int w;
      w = 0;
      udp_rx_tvalid = 1'b1;
      udp_rx_tdata  = d[i];
      udp_rx_tlast  = tlast_at_end && (i == d.size() - 1);
      @(negedge clock);
      while (!udp_rx_tready && w < 200) begin w++; @(negedge clock); end
      if (w >= 200) chk("tready_timeout", {31'd0, udp_rx_tready}, 32'd1);
      @(posedge clock); #1;
    end
    udp_rx_tvalid = 1'b0;
    udp_rx_tlast  = 1'b0;
  endtask

  task automatic run(input string nm, input bq_t d);
    hv_seen = 0; le_seen = 0; m_hv = 0; m_le = 0;
    model(d, lp);
    send(d, 1'b1);
    repeat (10) @(posedge clock);
    #1;
    chk({nm, "_queue_empty"}, exp_data.size(), 0);
    chk({nm, "_header_valid"}, hv_seen, m_hv);
    chk({nm, "_length_error"}, le_seen, m_le);
    chk({nm, "_drop_count"}, {16'd0, drop_count}, m_drop);
  endtask

  initial begin
    bq_t q;
    int r0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_app_valid", {31'd0, app_rx_tvalid}, 32'd0);
    chk("rst_drop", {16'd0, drop_count}, 32'd0);
    chk("rst_len", {16'd0, udp_length}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // 1: basic forward
    r0 = rcv_count;
    run("t1", mk(16'h1234, 16'h0400, 16'h0010, 8, 8'h01));
    chk("t1_src", {16'd0, source_udp_port}, 32'h1234);
    chk("t1_dst", {16'd0, dest_udp_port}, 32'h0400);
    chk("t1_len", {16'd0, udp_length}, 32'h0010);
    chk("t1_bytes", rcv_count - r0, 8);
    chk("t1_hv", hv_seen, 1);

    // 2: port mismatch, then matching datagram
    lp = 16'h0401;
    r0 = rcv_count;
    run("t2a", mk(16'h1234, 16'h0400, 16'h0010, 8, 8'h01));
    chk("t2_bytes", rcv_count - r0, 0);
    chk("t2_drop", {16'd0, drop_count}, 32'd1);
    lp = 16'h0400;
    run("t2b", mk(16'h1111, 16'h0400, 16'h000C, 4, 8'h20));

    // 3: padding trimmed
    r0 = rcv_count;
    run("t3", mk(16'h5555, 16'h0400, 16'h000A, 18, 8'h80));
    chk("t3_bytes", rcv_count - r0, 2);
    chk("t3_le", le_seen, 0);

    // 4: short datagram
    r0 = rcv_count;
    run("t4", mk(16'h7777, 16'h0400, 16'h001C, 4, 8'h30));
    chk("t4_bytes", rcv_count - r0, 4);
    chk("t4_le", le_seen, 1);

    // 5: app backpressure
    toggle = 1'b1;
    r0 = rcv_count;
    run("t5", mk(16'h1234, 16'h0400, 16'h0010, 8, 8'h01));
    chk("t5_bytes", rcv_count - r0, 8);
    toggle = 1'b0;
    @(posedge clock); #1;

    // header boundary cases
    q = mk(16'h0001, 16'h0400, 16'h0010, 0, 8'h00);
    q = q[0:4];
    run("trunc_hdr", q);
    run("len8_pad", mk(16'h0002, 16'h0400, 16'h0008, 3, 8'h50));
    chk("len8_hv", hv_seen, 1);
    run("len_lt8", mk(16'h0003, 16'h0400, 16'h0004, 4, 8'h60));
    run("tlast_b7", mk(16'h0004, 16'h0400, 16'h0010, 0, 8'h00));
    chk("tlast_b7_le", le_seen, 1);

    // 6: reset mid-payload just after byte 04 is accepted
    q = mk(16'h1234, 16'h0400, 16'h0010, 8, 8'h01);
    q = q[0:11];
    for (int i = 1; i <= 4; i++) begin exp_data.push_back(8'(i)); exp_last.push_back(1'b0); end
    send(q, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("t6_app_valid", {31'd0, app_rx_tvalid}, 32'd0);
    chk("t6_app_data", {24'd0, app_rx_tdata}, 32'd0);
    chk("t6_app_last", {31'd0, app_rx_tlast}, 32'd0);
    chk("t6_src", {16'd0, source_udp_port}, 32'd0);
    chk("t6_drop", {16'd0, drop_count}, 32'd0);
    chk("t6_tready", {31'd0, udp_rx_tready}, 32'd0);
    chk("t6_queue", exp_data.size(), 0);
    reset = 1'b0;
    m_drop = 0;
    @(posedge clock); #1;
    r0 = rcv_count;
    run("t6b", mk(16'h2222, 16'h0400, 16'h000D, 5, 8'h40));
    chk("t6b_bytes", rcv_count - r0, 5);
    chk("t6b_src", {16'd0, source_udp_port}, 32'h2222);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
